// File: rtl/raster_scan_gen_pkg.sv
// Shared types, widths and configuration check for the raster timing generator.
package raster_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_t;

    localparam int X_W       = 11;
    localparam int Y_W       = 12;
    localparam int CNT_W     = 12;
    localparam int COLOR_W   = 8;
    localparam int MAX_TOTAL = 4096;

    function automatic bit axis_params_ok(input int active, input int fp, input int sync,
                                          input int bp, input int max_active);
        return (active >= 1) && (active <= max_active) && (fp >= 1) && (sync >= 1) &&
               (bp >= 1) && ((active + fp + sync + bp) <= MAX_TOTAL);
    endfunction

endpackage

// File: rtl/raster_scan_gen_if.sv
// Pixel stream bundle: strobe into the generator, coordinates/colour/flags out.
interface raster_scan_gen_if;
    import raster_pkg::*;

    logic                en;
    logic [X_W-1:0]      x_out;
    logic [Y_W-1:0]      y_out;
    logic [COLOR_W-1:0]  r_out;
    logic [COLOR_W-1:0]  g_out;
    logic [COLOR_W-1:0]  b_out;
    logic                de;
    logic                hsync;
    logic                vsync;
    logic                pix_valid;
    logic                frame_start;

    modport master (
        input  en,
        output x_out, y_out, r_out, g_out, b_out,
        output de, hsync, vsync, pix_valid, frame_start
    );

    modport slave (
        output en,
        input  x_out, y_out, r_out, g_out, b_out,
        input  de, hsync, vsync, pix_valid, frame_start
    );

endinterface

// File: rtl/raster_scan_gen_timing_axis.sv
// One raster axis: position counter plus phase FSM; wrap pulses on the last BACK step.
//   state     | meaning
//   PH_ACTIVE | cnt in 0 .. ACTIVE-1
//   PH_FRONT  | cnt in front porch
//   PH_SYNC   | cnt in sync pulse
//   PH_BACK   | cnt in back porch, last value wraps to 0
module timing_axis
    import raster_pkg::*;
#(
    parameter int ACTIVE = 1920,
    parameter int FP     = 88,
    parameter int SYNC   = 44,
    parameter int BP     = 148
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [CNT_W-1:0] cnt,
    output phase_t           phase,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST_ACT  = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] LAST_FP   = CNT_W'(ACTIVE + FP - 1);
    localparam logic [CNT_W-1:0] LAST_SYNC = CNT_W'(ACTIVE + FP + SYNC - 1);
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(ACTIVE + FP + SYNC + BP - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    phase_t           phase_q, phase_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= PH_ACTIVE;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        wrap    = 1'b0;
        if (step) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                wrap  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            unique case (phase_q)
                PH_ACTIVE: if (cnt_q == LAST_ACT)  phase_d = PH_FRONT;
                PH_FRONT:  if (cnt_q == LAST_FP)   phase_d = PH_SYNC;
                PH_SYNC:   if (cnt_q == LAST_SYNC) phase_d = PH_BACK;
                PH_BACK:   if (cnt_q == LAST)      phase_d = PH_ACTIVE;
                default:   phase_d = PH_ACTIVE;
            endcase
        end
    end

    assign cnt   = cnt_q;
    assign phase = phase_q;

endmodule

// File: rtl/raster_scan_gen.sv
// Head-of-chain video timing generator: walks the raster one pixel per enabled
// clock and registers coordinates, background colour and sync/active flags.
module raster_scan_gen
    import raster_pkg::*;
#(
    parameter int                 H_ACTIVE = 1920,
    parameter int                 H_FP     = 88,
    parameter int                 H_SYNC   = 44,
    parameter int                 H_BP     = 148,
    parameter int                 V_ACTIVE = 1080,
    parameter int                 V_FP     = 4,
    parameter int                 V_SYNC   = 5,
    parameter int                 V_BP     = 36,
    parameter bit                 HS_POL   = 1'b1,
    parameter bit                 VS_POL   = 1'b1,
    parameter logic [COLOR_W-1:0] BG_R     = 8'h00,
    parameter logic [COLOR_W-1:0] BG_G     = 8'h00,
    parameter logic [COLOR_W-1:0] BG_B     = 8'h00
) (
    input  logic               clk,
    input  logic               rst,
    raster_scan_gen_if.master  bus
);

    localparam bit CFG_OK = axis_params_ok(H_ACTIVE, H_FP, H_SYNC, H_BP, 2048) &&
                            axis_params_ok(V_ACTIVE, V_FP, V_SYNC, V_BP, 4096);

    generate
        if (!CFG_OK) begin : g_cfg_err
            $error("raster_scan_gen: illegal raster timing parameters");
        end
    endgenerate

    logic [CNT_W-1:0] h_cnt, v_cnt;
    phase_t           h_phase, v_phase;
    logic             h_wrap;
    logic             v_wrap_unused;

    timing_axis #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_axis (
        .clk   (clk),
        .rst   (rst),
        .step  (bus.en),
        .cnt   (h_cnt),
        .phase (h_phase),
        .wrap  (h_wrap)
    );

    // h_wrap is already qualified by en, so the line advances in the same cycle.
    timing_axis #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_axis (
        .clk   (clk),
        .rst   (rst),
        .step  (h_wrap),
        .cnt   (v_cnt),
        .phase (v_phase),
        .wrap  (v_wrap_unused)
    );

    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic               de_q, de_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               pix_valid_q, pix_valid_d;
    logic               frame_start_q, frame_start_d;
    logic               de_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q           <= '0;
            y_q           <= '0;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            de_q          <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            pix_valid_q   <= pix_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        de_now        = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
        x_d           = x_q;
        y_d           = y_q;
        r_d           = r_q;
        g_d           = g_q;
        b_d           = b_q;
        de_d          = de_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        pix_valid_d   = bus.en;
        frame_start_d = 1'b0;
        if (bus.en) begin
            de_d          = de_now;
            x_d           = de_now ? h_cnt[X_W-1:0] : '0;
            y_d           = de_now ? v_cnt : '0;
            r_d           = de_now ? BG_R : '0;
            g_d           = de_now ? BG_G : '0;
            b_d           = de_now ? BG_B : '0;
            hsync_d       = (h_phase == PH_SYNC) ? HS_POL : ~HS_POL;
            vsync_d       = (v_phase == PH_SYNC) ? VS_POL : ~VS_POL;
            frame_start_d = (h_cnt == '0) && (v_cnt == '0);
        end
    end

    assign bus.x_out       = x_q;
    assign bus.y_out       = y_q;
    assign bus.r_out       = r_q;
    assign bus.g_out       = g_q;
    assign bus.b_out       = b_q;
    assign bus.de          = de_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.pix_valid   = pix_valid_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_raster_scan_gen.sv
// Scoreboard bench for raster_scan_gen on a small raster, both sync polarities.
module tb_raster_scan_gen;
    import raster_pkg::*;

    localparam int HA = 8, HF = 2, HS = 3, HB = 1;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam logic [7:0] BGR = 8'h12, BGG = 8'h34, BGB = 8'h56;

    // {x, y, r, g, b, de, hsync, vsync, frame_start}
    typedef logic [50:0] vec_t;
    localparam vec_t RST_P = 51'd0;
    localparam vec_t RST_N = 51'd6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    always #5 clk = ~clk;

    raster_scan_gen_if bus_p ();
    raster_scan_gen_if bus_n ();
    assign bus_p.en = en;
    assign bus_n.en = en;

    raster_scan_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .BG_R(BGR), .BG_G(BGG), .BG_B(BGB)
    ) dut_p (.clk(clk), .rst(rst), .bus(bus_p.master));

    raster_scan_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .BG_R(BGR), .BG_G(BGG), .BG_B(BGB)
    ) dut_n (.clk(clk), .rst(rst), .bus(bus_n.master));

    int   checks = 0;
    int   errors = 0;
    int   p = 0;
    vec_t q_p[$];
    vec_t q_n[$];
    vec_t held_p = RST_P;
    vec_t held_n = RST_N;
    logic rst_s = 1'b1;
    logic en_s  = 1'b0;

    // Reference: pixel index within the frame -> expected outputs.
    function automatic vec_t expect_pixel(input int idx, input bit pol);
        int h = idx % HT;
        int v = idx / HT;
        bit de_e = (h < HA) && (v < VA);
        bit hs_on = (h >= HA + HF) && (h < HA + HF + HS);
        bit vs_on = (v >= VA + VF) && (v < VA + VF + VS);
        return {de_e ? 11'(h) : 11'd0, de_e ? 12'(v) : 12'd0,
                de_e ? BGR : 8'd0, de_e ? BGG : 8'd0, de_e ? BGB : 8'd0,
                de_e, hs_on ? pol : ~pol, vs_on ? pol : ~pol, idx == 0};
    endfunction

    task automatic check(input string name, input vec_t act, input vec_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit e);
        @(posedge clk);
        #1;
        rst = r;
        en  = e;
        if (r) begin
            p = 0;
        end else if (e) begin
            q_p.push_back(expect_pixel(p, 1'b1));
            q_n.push_back(expect_pixel(p, 1'b0));
            p = (p + 1) % FRAME;
        end
    endtask

    always @(posedge clk) begin
        rst_s <= rst;
        en_s  <= en;
    end

    // Monitor: reset values, scoreboard pops on pix_valid, frozen outputs otherwise.
    always @(negedge clk) begin
        vec_t act_p, act_n, e;
        act_p = {bus_p.x_out, bus_p.y_out, bus_p.r_out, bus_p.g_out, bus_p.b_out,
                 bus_p.de, bus_p.hsync, bus_p.vsync, bus_p.frame_start};
        act_n = {bus_n.x_out, bus_n.y_out, bus_n.r_out, bus_n.g_out, bus_n.b_out,
                 bus_n.de, bus_n.hsync, bus_n.vsync, bus_n.frame_start};
        if (rst_s) begin
            check("reset_pos", act_p, RST_P);
            check("reset_neg", act_n, RST_N);
            check_bit("reset_pix_valid", bus_p.pix_valid | bus_n.pix_valid, 1'b0);
            held_p = RST_P;
            held_n = RST_N;
        end else begin
            check_bit("pix_valid_pos", bus_p.pix_valid, en_s);
            check_bit("pix_valid_neg", bus_n.pix_valid, en_s);
            if (bus_p.pix_valid) begin
                if (q_p.size() == 0) begin
                    check_bit("scoreboard_underflow_pos", 1'b1, 1'b0);
                end else begin
                    e = q_p.pop_front();
                    check("pixel_pos", act_p, e);
                    held_p = {e[50:1], 1'b0};
                end
            end else begin
                check("hold_pos", act_p, held_p);
            end
            if (bus_n.pix_valid) begin
                if (q_n.size() == 0) begin
                    check_bit("scoreboard_underflow_neg", 1'b1, 1'b0);
                end else begin
                    e = q_n.pop_front();
                    check("pixel_neg", act_n, e);
                    held_n = {e[50:1], 1'b0};
                end
            end else begin
                check("hold_neg", act_n, held_n);
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1);
        for (int i = 0; i < 2 * FRAME; i++) drive(1'b0, 1'b1);
        for (int i = 0; i < 2 * FRAME; i++) drive(1'b0, i[0]);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1);
            drive(1'b0, 1'b0);
            drive(1'b0, 1'b0);
            drive(1'b0, 1'b1);
        end
        for (int i = 0; i < 300; i++) drive(1'b0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < FRAME && p != 2 * HT + 5; i++) drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1);
        // Reset landing inside a vsync line must not leave a partial pulse.
        for (int i = 0; i < FRAME && p != (VA + VF) * HT + 3; i++) drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        for (int i = 0; i < FRAME + 30; i++) drive(1'b0, 1'b1);
        for (int i = 0; i < 400; i++) drive(1'b0, 1'($urandom_range(0, 3) != 0));
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check("scoreboard_drained", vec_t'(q_p.size() + q_n.size()), 51'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
